// File: rtl/trigger_capture.sv
// trigger_capture
//   Edge-triggered single-shot frame capture into a circular buffer.
//   Samples are written while a capture is active; once the trigger sample
//   and the remaining post-trigger samples are stored, the frame is frozen
//   and read back in time order (logical index 0 = oldest sample).
//
// Ports
//   adc_clk    : single clock
//   rst_n      : synchronous active-low reset
//   din        : 8-bit unsigned sample, qualified by din_valid
//   arm        : single-cycle start pulse (honoured in IDLE / DONE)
//   trig_level : unsigned trigger threshold
//   trig_edge  : 0 = rising, 1 = falling
//   pretrig    : samples kept ahead of the trigger, latched on arm
//   busy       : capture in progress
//   done       : frame complete and frozen
//   auto_trig  : last frame was force-triggered by the timeout
//   rd_en      : read request, honoured only in DONE
//   rd_addr    : logical read index
//   rd_data    : read data, one cycle after rd_en
//
// Build option
//   AUTO_TRIG_EN : when defined, a WAIT_TRIG timeout of AUTO_TMO cycles
//                  forces a trigger on the next valid sample.
module trigger_capture #(
    parameter int ADDR_W   = 10,
    parameter int AUTO_TMO = 50000
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic [7:0]        din,
    input  logic              din_valid,
    input  logic              arm,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pretrig,
    output logic              busy,
    output logic              done,
    output logic              auto_trig,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    state_t            arm_dest_s;
    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] pre_cnt_r;
    logic [ADDR_W-1:0] pre_len_r;
    logic [ADDR_W-1:0] post_cnt_r;
    logic [ADDR_W-1:0] start_addr_r;
    logic [ADDR_W-1:0] rd_phys_s;
    logic [7:0]        prev_r;
    logic              prev_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              auto_trig_r;
    logic [7:0]        rd_data_r;
    logic              busy_s;
    logic              done_s;
    logic              capturing_s;
    logic              we_s;
    logic              real_hit_s;
    logic              tmo_hit_s;
    logic              fire_s;
    logic              arm_ok_s;

    // Level-crossing test between the previous and the current valid sample.
    function automatic logic edge_hit(input logic [7:0] prev,
                                      input logic [7:0] cur,
                                      input logic [7:0] lvl,
                                      input logic       falling);
        if (falling) begin
            edge_hit = (prev > lvl) && (cur <= lvl);
        end else begin
            edge_hit = (prev < lvl) && (cur >= lvl);
        end
    endfunction

    // Shared qualifiers for write enable, trigger and arm acceptance.
    always_comb begin
        capturing_s = (state_r == ST_PRE) || (state_r == ST_WAIT) || (state_r == ST_POST);
        we_s        = capturing_s && din_valid && rst_n;
        real_hit_s  = prev_valid_r && edge_hit(prev_r, din, trig_level, trig_edge);
        arm_ok_s    = arm && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        arm_dest_s  = (pretrig == ADDR_ZERO) ? ST_WAIT : ST_PRE;
        rd_phys_s   = start_addr_r + rd_addr;
    end

`ifdef AUTO_TRIG_EN
    logic [31:0] tmo_cnt_r;

    // Timeout counter: free-runs in WAIT_TRIG regardless of din_valid, saturates at the limit.
    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            tmo_cnt_r <= 32'd0;
        end else if (state_r != ST_WAIT) begin
            tmo_cnt_r <= 32'd0;
        end else if (!tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
    end

    assign tmo_hit_s = (tmo_cnt_r >= 32'(AUTO_TMO));
`else
    logic unused_tmo_s;
    assign unused_tmo_s = (AUTO_TMO != 0);
    assign tmo_hit_s    = 1'b0;
`endif

    assign fire_s = real_hit_s || tmo_hit_s;

    // State register plus the registered status outputs derived from the next state.
    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; every transition out of a capture state needs a valid sample.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_s = arm_dest_s;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PRE: begin
                if (din_valid && ((pre_cnt_r + ADDR_ONE) == pre_len_r)) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_PRE;
                end
            end
            ST_WAIT: begin
                if (din_valid && fire_s) begin
                    // With pre_len = DEPTH-1 the trigger sample completes the frame.
                    state_s = (pre_len_r == ADDR_MAX) ? ST_DONE : ST_POST;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_POST: begin
                if (din_valid && (post_cnt_r == ADDR_ONE)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_POST;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight off flops.
    always_comb begin
        busy_s = (state_s == ST_PRE) || (state_s == ST_WAIT) || (state_s == ST_POST);
        done_s = (state_s == ST_DONE);
    end

    // Capture datapath: pointers, counters, previous-sample tracking, frame origin.
    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            wr_ptr_r     <= ADDR_ZERO;
            pre_cnt_r    <= ADDR_ZERO;
            pre_len_r    <= ADDR_ZERO;
            post_cnt_r   <= ADDR_ZERO;
            start_addr_r <= ADDR_ZERO;
            prev_r       <= 8'd0;
            prev_valid_r <= 1'b0;
            auto_trig_r  <= 1'b0;
        end else if (arm_ok_s) begin
            pre_len_r    <= pretrig;
            wr_ptr_r     <= ADDR_ZERO;
            pre_cnt_r    <= ADDR_ZERO;
            prev_valid_r <= 1'b0;
            auto_trig_r  <= 1'b0;
        end else if (capturing_s && din_valid) begin
            wr_ptr_r     <= wr_ptr_r + ADDR_ONE;
            prev_r       <= din;
            prev_valid_r <= 1'b1;
            case (state_r)
                ST_PRE: begin
                    if (pre_cnt_r != pre_len_r) begin
                        pre_cnt_r <= pre_cnt_r + ADDR_ONE;
                    end
                end
                ST_WAIT: begin
                    if (fire_s) begin
                        // Oldest sample sits pre_len slots behind the trigger slot.
                        start_addr_r <= wr_ptr_r - pre_len_r;
                        // DEPTH - pre_len - 1 equals the bitwise complement in ADDR_W bits.
                        post_cnt_r   <= ~pre_len_r;
                        auto_trig_r  <= tmo_hit_s && !real_hit_s;
                    end
                end
                ST_POST: post_cnt_r <= post_cnt_r - ADDR_ONE;
                default: post_cnt_r <= post_cnt_r;
            endcase
        end
    end

    // Sample buffer write port (no reset so it maps onto block RAM).
    always_ff @(posedge adc_clk) begin
        if (we_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Registered read port, active only on a frozen frame.
    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            rd_data_r <= 8'd0;
        end else if (rd_en && (state_r == ST_DONE)) begin
            rd_data_r <= mem_r[rd_phys_s];
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign auto_trig = auto_trig_r;
    assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed testbench for trigger_capture with ADDR_W = 4 (16-sample frames).
module tb_trigger_capture;

    localparam int ADDR_W = 4;

    logic              adc_clk = 1'b0;
    logic              rst_n;
    logic [7:0]        din;
    logic              din_valid;
    logic              arm;
    logic [7:0]        trig_level;
    logic              trig_edge;
    logic [ADDR_W-1:0] pretrig;
    logic              busy;
    logic              done;
    logic              auto_trig;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    int total = 0;
    int bad   = 0;

    trigger_capture #(.ADDR_W(ADDR_W), .AUTO_TMO(20)) dut (
        .adc_clk    (adc_clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .arm        (arm),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .pretrig    (pretrig),
        .busy       (busy),
        .done       (done),
        .auto_trig  (auto_trig),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic tick;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_it(input logic [ADDR_W-1:0] pt, input logic [7:0] lvl, input logic edg);
        pretrig    = pt;
        trig_level = lvl;
        trig_edge  = edg;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic rd(input int a, input logic [7:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(a);
        tick();
        rd_en   = 1'b0;
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; din = 8'd0; din_valid = 1'b1; arm = 1'b0;
        trig_level = 8'd0; trig_edge = 1'b0; pretrig = 4'd0;
        rd_en = 1'b0; rd_addr = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_auto", {31'd0, auto_trig}, 32'd0);
        chk("reset_rd_data", {24'd0, rd_data}, 32'd0);

        // Rising trigger, pretrig 4, ramp 0x00,0x10,...; trigger on 0x80 (k=8).
        arm_it(4'd4, 8'h80, 1'b0);
        chk("t1_busy_after_arm", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            din = 8'(k * 16);
            tick();
            if (k == 18) chk("t1_done_early", {31'd0, done}, 32'd0);
            if (k == 19) begin
                chk("t1_done", {31'd0, done}, 32'd1);
                chk("t1_busy_end", {31'd0, busy}, 32'd0);
            end
        end
        for (int i = 0; i < 16; i++) begin
            rd(i, 8'(8'h40 + 16 * i), "t1_read");
        end

        // Falling trigger, level 0x40, descending from 0xF0, pretrig 0; trigger at k=11.
        arm_it(4'd0, 8'h40, 1'b1);
        rd_en = 1'b1; rd_addr = 4'd0;
        for (int k = 0; k < 27; k++) begin
            din = 8'(240 - 16 * k);
            tick();
            if (k == 0) begin
                rd_en = 1'b0;
                chk("t2_rd_hold", {24'd0, rd_data}, 32'h30);
            end
            if (k == 25) chk("t2_done_early", {31'd0, done}, 32'd0);
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        rd(0, 8'h40, "t2_rd0");
        rd(1, 8'h30, "t2_rd1");
        rd(15, 8'h50, "t2_rd15");

        // Wrap-around: pretrig 15, 40 quiet samples then 0xC0 triggers.
        arm_it(4'd15, 8'h80, 1'b0);
        for (int k = 0; k <= 40; k++) begin
            din = (k == 40) ? 8'hC0 : 8'(k);
            tick();
            if (k == 39) chk("t3_done_early", {31'd0, done}, 32'd0);
        end
        chk("t3_done", {31'd0, done}, 32'd1);
        rd(15, 8'hC0, "t3_rd15");
        rd(0, 8'h19, "t3_rd0");
        rd(7, 8'h20, "t3_rd7");

        // Constant input equal to the level never crosses it; arm in WAIT is ignored.
        arm_it(4'd2, 8'h80, 1'b0);
        for (int k = 0; k < 40; k++) begin
            din = 8'h80;
            arm = (k == 30);
            pretrig = 4'd0;
            tick();
        end
        arm = 1'b0;
`ifdef AUTO_TRIG_EN
        chk("t4_auto_trig", {31'd0, auto_trig}, 32'd1);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
`else
        chk("t4_auto_trig", {31'd0, auto_trig}, 32'd0);
        chk("t4_done", {31'd0, done}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t4_reset_busy", {31'd0, busy}, 32'd0);

        // din_valid alternating during POST; frame holds only valid samples.
        arm_it(4'd4, 8'h80, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            din = 8'(k * 16);
            tick();
        end
        for (int j = 0; j < 11; j++) begin
            if (j > 0) begin
                din_valid = 1'b0; din = 8'hFF;
                tick();
                chk("t5_done_gap", {31'd0, done}, 32'd0);
            end
            din_valid = 1'b1; din = 8'(8'h90 + 16 * j);
            tick();
            if (j == 9) chk("t5_done_early", {31'd0, done}, 32'd0);
        end
        chk("t5_done", {31'd0, done}, 32'd1);
        rd(0, 8'h40, "t5_rd0");
        rd(5, 8'h90, "t5_rd5");
        rd(15, 8'h30, "t5_rd15");

        // Reset in mid-POST, then re-arm with offset ramp (trigger on 0x85).
        arm_it(4'd4, 8'h80, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            din = 8'(k * 16);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        arm_it(4'd4, 8'h80, 1'b0);
        for (int k = 0; k < 20; k++) begin
            din = 8'(k * 16 + 5);
            tick();
        end
        chk("t6_done", {31'd0, done}, 32'd1);
        rd(0, 8'h45, "t6_rd0");
        rd(4, 8'h85, "t6_rd4");
        rd(15, 8'h35, "t6_rd15");

        // Arm and read in the same DONE cycle: read returns the frozen frame.
        arm = 1'b1; pretrig = 4'd4; rd_en = 1'b1; rd_addr = 4'd4;
        tick();
        arm = 1'b0; rd_en = 1'b0;
        chk("t7_rd_with_arm", {24'd0, rd_data}, 32'h85);
        chk("t7_busy", {31'd0, busy}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Downstream of the interleaved ADC receive stage: consumes the 8-bit sample stream on `adc_clk`, detects an edge trigger against a programmable level, and records one frame into an internal circular BRAM with programmable pre-trigger depth. After capture the frame is frozen and read out in time order, oldest sample first, by the display/host side. One capture per `arm` pulse (single-shot). The host re-arms for the next frame.

## Interface
- `ADDR_W`, 10: buffer address width; depth `DEPTH = 2**ADDR_W` samples.
- `AUTO_TMO`, 50000: `adc_clk` cycles in WAIT_TRIG before a forced trigger. Used only with `AUTO_TRIG_EN`.

- `adc_clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `din` in 8: ADC sample, unsigned.
- `din_valid` in 1: `din` is a valid sample this cycle; may be tied high.
- `arm` in 1: single-cycle start pulse.
- `trig_level` in 8: trigger threshold, unsigned.
- `trig_edge` in 1: 0 = rising, 1 = falling.
- `pretrig` in `ADDR_W`: samples kept before the trigger sample. Sampled on `arm`.
- `busy` out 1: capture in progress (PRE, WAIT_TRIG, POST).
- `done` out 1: frame complete and frozen.
- `auto_trig` out 1: last frame was force-triggered.
- `rd_en` in 1: read request. Honoured only in DONE.
- `rd_addr` in `ADDR_W`: logical index; 0 = oldest sample of the frame.
- `rd_data` out 8: read data.

## Operation
- States:
  - IDLE: no capture. Exits to PRE on `arm`.
  - PRE: write samples until `pre_cnt` reaches the latched `pretrig`.
  - WAIT_TRIG: write samples and search for a trigger.
  - POST: write remaining samples until `post_cnt` is 0.
  - DONE: writes stopped, buffer readable.
- On `arm` in IDLE or DONE:
  - latch `pretrig` to `pre_len`;
  - clear `wr_ptr`, `pre_cnt`, `prev_valid`, `done`, `auto_trig`;
  - go to PRE, or straight to WAIT_TRIG if `pretrig`=0.
- `arm` in PRE, WAIT_TRIG or POST is ignored.
- Every `din_valid` cycle in PRE, WAIT_TRIG or POST:
  - write `din` at `wr_ptr`;
  - `wr_ptr` increments modulo `DEPTH` (wraps from `DEPTH`-1 to 0).
- Cycles with `din_valid`=0 stall all counters and the FSM. The auto-timeout counter is the exception; see Configuration.
- Trigger condition, evaluated on valid samples:
  - rising: `prev < trig_level` and `din >= trig_level`;
  - falling: `prev > trig_level` and `din <= trig_level`;
  - `prev` is the last valid sample. No trigger while `prev_valid`=0, i.e. the first sample after `arm` cannot trigger.
- PRE to WAIT_TRIG: when `pre_cnt` reaches `pre_len`. `pre_cnt` saturates; triggers are ignored in PRE.
- WAIT_TRIG to POST, on the trigger sample:
  - `trig_addr` = that sample's `wr_ptr`;
  - `post_cnt` = `DEPTH - pre_len - 1`;
  - if `post_cnt`=0 (`pre_len`=`DEPTH`-1), go directly to DONE.
- POST: decrement `post_cnt` per valid sample; when it reaches 0, the next cycle is DONE.
- DONE:
  - `start_addr` = `trig_addr - pre_len` (mod `DEPTH`);
  - physical read address = `start_addr + rd_addr` (mod `DEPTH`).
- Reads in any state other than DONE are ignored; `rd_data` holds its value.
- Logical index `pre_len` is always the trigger sample.

## Timing
- Reset values:
  - state = IDLE;
  - `busy`=0, `done`=0, `auto_trig`=0, `rd_data`=0;
  - all pointers and counters = 0.
- `arm` at cycle N: `busy`=1 from N+1.
- The trigger sample is written in the same cycle it is detected.
- `done`=1 and `busy`=0 on the cycle after the last sample is written; both held until the next `arm`.
- Total samples written per frame: `DEPTH` (`pre_len` + 1 + `post_cnt`).
- Read latency: `rd_en` at cycle N gives `rd_data` at N+1. One read per cycle, back-to-back.
- Reset mid-capture: next cycle is IDLE, `busy`=0, `done`=0. Buffer contents are undefined.
- `arm` and `rd_en` in the same DONE cycle: the read completes with old contents, then capture restarts.

## Configuration
- `AUTO_TRIG_EN` defined:
  - a 32-bit counter runs every cycle in WAIT_TRIG (counts even when `din_valid`=0) and clears on entry;
  - when it reaches `AUTO_TMO`, the next valid sample is treated as the trigger sample and `auto_trig`=1.
  - A real trigger on that same sample takes priority: `auto_trig`=0.
- `AUTO_TRIG_EN` undefined: no counter; WAIT_TRIG waits indefinitely; `auto_trig` tied 0.

## Test plan
Bench uses `ADDR_W`=4 (`DEPTH`=16) and `din_valid`=1 unless stated.
- Rising trigger, `pretrig`=4, `trig_level`=0x80, ramp 0x00,0x10,…:
  - first sample ≥0x80 is 0x80;
  - reads 0..15 return 0x40,0x50,0x60,0x70,0x80,…,0x130 truncated to 8 bits;
  - `done` rises 12 cycles after the trigger cycle.
- Falling trigger, `trig_edge`=1, level 0x40, descending ramp from 0xF0, `pretrig`=0: `rd_addr`=0 returns the first sample ≤0x40.
- Wrap-around, `pretrig`=15, trigger after 40 samples:
  - `done` the cycle after the trigger;
  - `rd_addr`=15 returns the trigger sample;
  - `rd_addr`=0 returns the sample 15 earlier.
- Constant `din`=0x80 equal to level: no trigger; `busy` stays 1. With `AUTO_TRIG_EN` and `AUTO_TMO`=20: `auto_trig`=1 and `done`=1.
- `din_valid` toggling 1,0 during POST: frame still holds exactly 16 consecutive valid samples; `done` is delayed correspondingly.
- `rst_n`=0 for one cycle mid-POST: `busy`=0 and `done`=0 next cycle; a re-arm captures a correct frame.
